// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared CPU memory/MMIO bus.
// Runs one transaction at a time with registered completion back to the masters and a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,

  output logic        grant,
  output logic        timeout_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic              grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              to_flag, to_flag_nxt;
  logic [31:0]       m0_rdata_nxt, m1_rdata_nxt;

  // NOTE: reset is synchronous, so only clk appears in the sensitivity list;
  // all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      to_flag    <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      to_flag    <= to_flag_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_rdata   <= m1_rdata_nxt;
    end
  end

  // NOTE: every output of this block gets a hold-value default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    to_flag_nxt    = to_flag;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;

    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // A tie goes to whoever did not own the previous transaction.
          if (m0_valid && m1_valid) grant_nxt = ~last_grant;
          else                      grant_nxt = m1_valid;
          last_grant_nxt = grant_nxt;
          cnt_nxt        = '0;
          to_flag_nxt    = 1'b0;
          state_nxt      = ACTIVE;
        end
      end

      ACTIVE: begin
        // A slave answer on the expiry cycle still counts as a normal completion.
        if (bus_ready) begin
          if (grant) m1_rdata_nxt = bus_rdata;
          else       m0_rdata_nxt = bus_rdata;
          to_flag_nxt = 1'b0;
          state_nxt   = RESP;
        end else if (cnt == CNT_LAST) begin
          if (grant) m1_rdata_nxt = ERR_RDATA;
          else       m0_rdata_nxt = ERR_RDATA;
          to_flag_nxt = 1'b1;
          state_nxt   = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The bus side is driven only while a transaction owns it; zeros otherwise.
  always_comb begin
    bus_valid = 1'b0;
    bus_instr = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    if (state == ACTIVE) begin
      bus_valid = 1'b1;
      if (grant) begin
        bus_instr = m1_instr;
        bus_addr  = m1_addr;
        bus_wdata = m1_wdata;
        bus_wstrb = m1_wstrb;
      end else begin
        bus_instr = m0_instr;
        bus_addr  = m0_addr;
        bus_wdata = m0_wdata;
        bus_wstrb = m0_wstrb;
      end
    end
  end

  // Completion outputs decode straight from flops, so they are glitch-free pulses.
  assign m0_ready    = (state == RESP) && !grant;
  assign m1_ready    = (state == RESP) &&  grant;
  assign timeout_err = (state == RESP) &&  to_flag;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-master scoreboards filled at request time,
// drained when the matching ready pulse appears; a small slave model answers the bus.
module tb_mem_bus_arbiter;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hBADC_0FFE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_valid = 1'b0, m0_instr = 1'b0, m0_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0, m1_instr = 1'b0, m1_ready;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
  logic [3:0]  m1_wstrb = '0;
  logic        bus_valid, bus_instr, bus_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_wstrb;
  logic        grant, timeout_err;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .bus_valid(bus_valid), .bus_instr(bus_instr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  logic gq[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   slave_delay = 0;
  logic force_ready = 1'b0;
  int   vcnt = 0;
  int   m0_left = 0, m1_left = 0;
  int   rdy0 = 0, rdy1 = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h4000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins, input logic to);
    exp_t e;
    e.rdata = to ? ERR : slave_data(a);
    e.to    = to;
    if (!m) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins;
      exp_q0.push_back(e);
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins;
      exp_q1.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q0.size() + exp_q1.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Counts bus_valid cycles of one transaction until the granted master's ready.
  task automatic count_active(input int budget, output int n_valid);
    int k = 0;
    n_valid = 0;
    while (!m0_ready && !m1_ready && k < budget) begin
      @(negedge clk);
      if (bus_valid) n_valid++;
      k++;
    end
  endtask

  task automatic reset_in_active(input logic m);
    slave_delay = -1;
    @(posedge clk); #1 issue(m, 32'h5000_0000, 0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_bus_valid", 32'(bus_valid), 0);
    chk("t6_grant", 32'(grant), 0);
    chk("t6_ready", 32'({m0_ready, m1_ready}), 0);
    // Tie right after reset must go to m0.
    slave_delay = 0;
    gq.push_back(1'b0); gq.push_back(1'b1);
    @(posedge clk); #1;
    issue(1'b0, 32'h5000_0100, 0, 4'h0, 1'b0, 1'b0);
    issue(1'b1, 32'h5000_0200, 0, 4'h0, 1'b0, 1'b0);
    wait_done("t6_tie_done", 40);
  endtask

  // Slave model: answers slave_delay cycles into ACTIVE (negative = never).
  initial begin
    forever begin
      @(negedge clk);
      vcnt = bus_valid ? vcnt + 1 : 0;
      bus_ready = 1'b0;
      bus_rdata = '0;
      if (force_ready) begin
        bus_ready = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        force_ready = 1'b0;
      end else if (bus_valid && slave_delay >= 0 && vcnt == slave_delay + 1) begin
        bus_ready = 1'b1;
        bus_rdata = slave_data(bus_addr);
      end
    end
  end

  // Response monitor and master model: pops scoreboards, re-requests when asked.
  initial begin
    forever begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        chk("dual_ready", 32'(m0_ready & m1_ready), 0);
        if (gq.size() > 0) chk("grant_order", 32'(grant), 32'(gq.pop_front()));
        if (m0_ready) begin
          rdy0++;
          if (exp_q0.size() == 0) chk("m0_unexpected_ready", 0, 1);
          else begin
            mon_e = exp_q0.pop_front();
            chk("m0_rdata", m0_rdata, mon_e.rdata);
            chk("m0_timeout_err", 32'(timeout_err), 32'(mon_e.to));
          end
          if (m0_left > 0) begin
            m0_left--;
            issue(1'b0, 32'h1000_0000 + 32'(m0_left) * 4, 0, 4'h0, 1'b1, 1'b0);
          end else m0_valid = 1'b0;
        end
        if (m1_ready) begin
          rdy1++;
          if (exp_q1.size() == 0) chk("m1_unexpected_ready", 0, 1);
          else begin
            mon_e = exp_q1.pop_front();
            chk("m1_rdata", m1_rdata, mon_e.rdata);
            chk("m1_timeout_err", 32'(timeout_err), 32'(mon_e.to));
          end
          if (m1_left > 0) begin
            m1_left--;
            issue(1'b1, 32'h2000_0000 + 32'(m1_left) * 4, 0, 4'h0, 1'b0, 1'b0);
          end else m1_valid = 1'b0;
        end
      end else if (timeout_err) begin
        chk("stray_timeout_err", 32'(timeout_err), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, r0, r1;
    logic found;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_ready", 32'({m0_ready, m1_ready}), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: single m0 read, latency and data
    @(posedge clk); #1;
    slave_delay = 0;
    gq.push_back(1'b0);
    issue(1'b0, 32'h4000_0010, 0, 4'h0, 1'b0, 1'b0);
    @(negedge clk); chk("t1_valid_lat0", 32'(bus_valid), 0);
    @(negedge clk); chk("t1_valid_lat1", 32'(bus_valid), 1);
    chk("t1_bus_addr", bus_addr, 32'h4000_0010);
    chk("t1_grant", 32'(grant), 0);
    @(negedge clk); chk("t1_m0_ready", 32'(m0_ready), 1);
    wait_done("t1_done", 20);

    // 2: contending masters alternate
    do_reset();
    r0 = rdy0; r1 = rdy1;
    m0_left = 3; m1_left = 3;
    for (int i = 0; i < 4; i++) begin
      gq.push_back(1'b0); gq.push_back(1'b1);
    end
    @(posedge clk); #1;
    issue(1'b0, 32'h1000_0100, 0, 4'h0, 1'b1, 1'b0);
    issue(1'b1, 32'h2000_0100, 0, 4'h0, 1'b0, 1'b0);
    wait_done("t2_done", 200);
    chk("t2_grant_q_left", 32'(gq.size()), 0);
    chk("t2_m0_count", 32'(rdy0 - r0), 4);
    chk("t2_m1_count", 32'(rdy1 - r1), 4);

    // 3: m1 write muxed onto the bus while m0 waits
    slave_delay = 2;
    gq.push_back(1'b1); gq.push_back(1'b0);
    @(posedge clk); #1 issue(1'b1, 32'hC100_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
    @(posedge clk); #1 issue(1'b0, 32'h0000_0100, 32'hAAAA_5555, 4'h3, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_bus_valid", 32'(bus_valid), 1);
    chk("t3_grant", 32'(grant), 1);
    chk("t3_bus_addr", bus_addr, 32'hC100_0000);
    chk("t3_bus_wdata", bus_wdata, 32'h1234_5678);
    chk("t3_bus_wstrb", 32'(bus_wstrb), 32'hF);
    chk("t3_bus_instr", 32'(bus_instr), 0);
    chk("t3_m0_no_ready", 32'(m0_ready), 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = bus_valid && !grant;
    end
    chk("t3_m0_bus_addr", bus_addr, 32'h0000_0100);
    chk("t3_m0_bus_wstrb", 32'(bus_wstrb), 32'h3);
    chk("t3_m0_bus_instr", 32'(bus_instr), 1);
    wait_done("t3_done", 40);

    // 4: timeout, then a late bus_ready that must be ignored
    slave_delay = -1;
    @(posedge clk); #1 issue(1'b0, 32'h4000_0020, 0, 4'h0, 1'b0, 1'b1);
    count_active(60, n);
    chk("t4_valid_cycles", n, TO);
    chk("t4_timeout_with_ready", 32'({m0_ready, timeout_err}), 32'h3);
    @(posedge clk); @(posedge clk); #1 force_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_late_rdata_hold", m0_rdata, ERR);
    chk("t4_late_bus_valid", 32'(bus_valid), 0);
    wait_done("t4_done", 10);

    // 5: slave answers on the expiry cycle -> normal completion
    slave_delay = TO - 1;
    @(posedge clk); #1 issue(1'b0, 32'h4000_0030, 0, 4'h0, 1'b0, 1'b0);
    count_active(60, n);
    chk("t5_valid_cycles", n, TO);
    chk("t5_timeout_err", 32'(timeout_err), 0);
    wait_done("t5_done", 10);

    // 6: reset during ACTIVE, owned by m1 and then by m0
    reset_in_active(1'b1);
    reset_in_active(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
